// File: rtl/latch_write_ctrl.sv
// latch_write_ctrl: sequences a single write into a bank of level-sensitive
// latches. The data is presented first, then the enable is pulsed, and then
// the data is held. Finally the latch outputs are read back and compared.
// Every output comes straight from a flop, so lat_e and lat_d never glitch.
module latch_write_ctrl #(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] lat_d,
  output logic              lat_e,
  input  logic [DATA_W-1:0] lat_q,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  // Phase counter reload values; each phase ends when the counter reads zero.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        phase_q, phase_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              lat_e_q, lat_e_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  // State, phase counter and registered outputs; reset aborts any write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= 8'd0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      lat_e_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      lat_e_q   <= lat_e_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state logic: each timed phase reloads the counter on entry and exits on zero.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = SETUP;
          phase_d = SETUP_LD;
        end
      end
      SETUP: begin
        if (phase_q == 8'd0) begin
          state_d = PULSE;
          phase_d = PULSE_LD;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      PULSE: begin
        if (phase_q == 8'd0) begin
          state_d = HOLD;
          phase_d = HOLD_LD;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      HOLD: begin
        if (phase_q == 8'd0) begin
          state_d = CHECK;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        phase_d = 8'd0;
      end
      default: begin
        state_d = IDLE;
        phase_d = 8'd0;
      end
    endcase
  end

  // Output next values are derived from the upcoming state, so each flop is valid for the whole state.
  always_comb begin
    ready_d   = (state_d == IDLE);
    lat_e_d   = (state_d == PULSE);
    data_d    = data_q;
    if ((state_q == IDLE) && wr_req) begin
      data_d = wr_data;
    end
    done_d    = (state_q == HOLD) && (state_d == CHECK);
    err_d     = done_d && (lat_q != data_q);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign wr_ready = ready_q;
  assign lat_d    = data_q;
  assign lat_e    = lat_e_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Bench for latch_write_ctrl. Two instances share one stimulus: the default
// timing with a latch that can be forced to read back zero, and the minimum
// 1/1/1 timing with a healthy latch. Each write is predicted from its
// acceptance edge with plain arithmetic on the phase lengths.
module tb_latch_write_ctrl;

  localparam int S0 = 2, P0 = 3, H0 = 2;
  localparam int S1 = 1, P1 = 1, H1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       faultLat;

  logic       ready0, ready1, latE0, latE1, done0, done1, err0, err1;
  logic [7:0] latD0, latD1, errCnt0, errCnt1;
  logic [7:0] latQ0 = 8'h00;
  logic [7:0] latQ1 = 8'h00;

  int testsRun = 0;
  int testsFailed = 0;

  int         edgeNum;
  bit         accValid [2];
  int         accEdge [2];
  logic [7:0] expData [2];
  bit         expMis [2];
  int         expErrCnt [2];
  bit         newAcc [2];
  bit         prevReady [2];
  int         obsAccEdge [2];
  int         pulseSeen [2];
  int         doneCycle [2];
  int         errAtDone [2];

  always #5 clk = ~clk;

  latch_write_ctrl #(.DATA_W(8), .SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0)) dut0 (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_ready(ready0),
    .lat_d(latD0), .lat_e(latE0), .lat_q(latQ0), .done(done0), .err(err0), .err_cnt(errCnt0)
  );

  latch_write_ctrl #(.DATA_W(8), .SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1)) dut1 (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_ready(ready1),
    .lat_d(latD1), .lat_e(latE1), .lat_q(latQ1), .done(done1), .err(err1), .err_cnt(errCnt1)
  );

  // Latch model for instance 0; faultLat forces Q to read back as zero.
  always @(latE0 or latD0 or faultLat) begin
    if (faultLat) latQ0 = 8'h00;
    else if (latE0) latQ0 = latD0;
  end

  // Healthy latch model for instance 1.
  always @(latE1 or latD1) begin
    if (latE1) latQ1 = latD1;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int sOf(int m); return (m == 0) ? S0 : S1; endfunction
  function automatic int pOf(int m); return (m == 0) ? P0 : P1; endfunction
  function automatic int hOf(int m); return (m == 0) ? H0 : H1; endfunction
  function automatic int lenOf(int m); return sOf(m) + pOf(m) + hOf(m) + 1; endfunction
  function automatic int relOf(int m); return edgeNum - accEdge[m]; endfunction
  function automatic bit busy(int m); return accValid[m] && (relOf(m) < lenOf(m)); endfunction

  function automatic logic obsReady(int m); return (m == 0) ? ready0 : ready1; endfunction
  function automatic logic obsLatE(int m); return (m == 0) ? latE0 : latE1; endfunction
  function automatic logic obsDone(int m); return (m == 0) ? done0 : done1; endfunction
  function automatic logic obsErr(int m); return (m == 0) ? err0 : err1; endfunction
  function automatic logic [7:0] obsLatD(int m); return (m == 0) ? latD0 : latD1; endfunction
  function automatic logic [7:0] obsErrCnt(int m); return (m == 0) ? errCnt0 : errCnt1; endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    testsRun++;
    testsFailed++;
    $error("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic resetModel();
    edgeNum = 0;
    for (int m = 0; m < 2; m++) begin
      accValid[m]   = 1'b0;
      accEdge[m]    = 0;
      expData[m]    = 8'h00;
      expMis[m]     = 1'b0;
      expErrCnt[m]  = 0;
      newAcc[m]     = 1'b0;
      prevReady[m]  = 1'b1;
      obsAccEdge[m] = 0;
      pulseSeen[m]  = 0;
      doneCycle[m]  = 0;
      errAtDone[m]  = 0;
    end
  endtask

  task automatic checkReset(input string tag);
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("%s_d%0d_ready", tag, m), obsReady(m), 1);
      checkOutput($sformatf("%s_d%0d_late", tag, m), obsLatE(m), 0);
      checkOutput($sformatf("%s_d%0d_latd", tag, m), obsLatD(m), 0);
      checkOutput($sformatf("%s_d%0d_done", tag, m), obsDone(m), 0);
      checkOutput($sformatf("%s_d%0d_err", tag, m), obsErr(m), 0);
      checkOutput($sformatf("%s_d%0d_errcnt", tag, m), obsErrCnt(m), 0);
    end
  endtask

  // One clock: predict acceptance, advance, then compare every output of both instances.
  task automatic stepCycle();
    for (int m = 0; m < 2; m++) begin
      if (wr_req && !busy(m)) begin
        accValid[m] = 1'b1;
        accEdge[m]  = edgeNum + 1;
        expData[m]  = wr_data;
        expMis[m]   = (m == 0) && faultLat && (wr_data != 8'h00);
        newAcc[m]   = 1'b1;
      end
    end
    @(posedge clk);
    edgeNum++;
    #1;
    for (int m = 0; m < 2; m++) begin
      int  r;
      bit  b;
      bit  eDone;
      r     = relOf(m);
      b     = busy(m);
      eDone = accValid[m] && (r == sOf(m) + pOf(m) + hOf(m));
      if (eDone && expMis[m] && expErrCnt[m] < 255) expErrCnt[m]++;
      checkOutput($sformatf("d%0d_ready_e%0d", m, edgeNum), obsReady(m), !b);
      checkOutput($sformatf("d%0d_late_e%0d", m, edgeNum), obsLatE(m),
                  b && (r >= sOf(m)) && (r < sOf(m) + pOf(m)));
      checkOutput($sformatf("d%0d_latd_e%0d", m, edgeNum), obsLatD(m), expData[m]);
      checkOutput($sformatf("d%0d_done_e%0d", m, edgeNum), obsDone(m), eDone);
      checkOutput($sformatf("d%0d_err_e%0d", m, edgeNum), obsErr(m), eDone && expMis[m]);
      checkOutput($sformatf("d%0d_errcnt_e%0d", m, edgeNum), obsErrCnt(m), expErrCnt[m]);
      if (prevReady[m] && !obsReady(m)) begin
        obsAccEdge[m] = edgeNum;
        pulseSeen[m]  = 0;
      end
      if (obsLatE(m)) pulseSeen[m]++;
      if (obsDone(m)) begin
        doneCycle[m] = edgeNum - obsAccEdge[m] + 1;
        errAtDone[m] = int'(obsErr(m));
      end
      prevReady[m] = obsReady(m);
    end
  endtask

  // Issue one write and run until instance 0 reaches its readback cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic f);
    int guard;
    wr_data   = data;
    faultLat  = f;
    wr_req    = 1'b1;
    newAcc[0] = 1'b0;
    newAcc[1] = 1'b0;
    guard = 0;
    while (!newAcc[0] && guard < 40) begin
      stepCycle();
      guard++;
    end
    if (!newAcc[0]) timeoutFail("accept_wait");
    guard = 0;
    while (busy(0) && relOf(0) != S0 + P0 + H0 && guard < 40) begin
      wr_req  = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      stepCycle();
      guard++;
    end
    if (guard >= 40) timeoutFail("done_wait");
    wr_req = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((busy(0) || busy(1)) && guard < 600) begin
      stepCycle();
      guard++;
    end
    if (guard >= 600) timeoutFail("idle_wait");
  endtask

  initial begin
    int firstAcc;
    int guard;
    rst = 1'b1;
    wr_req = 1'b0;
    wr_data = 8'h00;
    faultLat = 1'b0;
    resetModel();

    #2;
    checkReset("rst_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();

    // Healthy write of 0xA5: pulse length and done cycle for both timings.
    applyStimulus(8'hA5, 1'b0);
    stepCycle();
    checkOutput("a5_done_cycle", doneCycle[0], 8);
    checkOutput("a5_pulse_len", pulseSeen[0], 3);
    checkOutput("a5_err", errAtDone[0], 0);
    checkOutput("min_done_cycle", doneCycle[1], 4);
    checkOutput("min_pulse_len", pulseSeen[1], 1);
    waitIdle();

    // Stuck-at-zero readback: err coincides with done and the count becomes 1.
    applyStimulus(8'h3C, 1'b1);
    checkOutput("stuck_done_cycle", doneCycle[0], 8);
    checkOutput("stuck_err", errAtDone[0], 1);
    checkOutput("stuck_errcnt", errCnt0, 1);
    waitIdle();

    // Request held high: the second write lands one idle cycle after the first completes.
    faultLat = 1'b0;
    wr_data = 8'h11;
    wr_req = 1'b1;
    newAcc[0] = 1'b0;
    guard = 0;
    while (!newAcc[0] && guard < 20) begin stepCycle(); guard++; end
    firstAcc = obsAccEdge[0];
    wr_data = 8'h22;
    newAcc[0] = 1'b0;
    guard = 0;
    while (!newAcc[0] && guard < 20) begin stepCycle(); guard++; end
    stepCycle();
    checkOutput("b2b_gap", obsAccEdge[0] - firstAcc, 9);
    wr_req = 1'b0;
    waitIdle();

    // Randomized writes with random gaps, data and latch health.
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) stepCycle();
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)));
    end
    waitIdle();

    // Reset in the middle of the enable pulse.
    faultLat = 1'b0;
    applyStimulus(8'h6B, 1'b1);
    waitIdle();
    wr_data = 8'h77;
    wr_req = 1'b1;
    newAcc[0] = 1'b0;
    guard = 0;
    while (!newAcc[0] && guard < 20) begin stepCycle(); guard++; end
    wr_req = 1'b0;
    guard = 0;
    while (relOf(0) != S0 && guard < 20) begin stepCycle(); guard++; end
    checkOutput("pre_rst_late", latE0, 1);
    rst = 1'b1;
    #1;
    checkReset("rst_pulse");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkReset($sformatf("rst_hold%0d", k));
    end
    rst = 1'b0;
    resetModel();
    wr_data = 8'h5E;
    wr_req = 1'b1;
    stepCycle();
    checkOutput("post_rst_accept", ready0, 0);
    wr_req = 1'b0;
    waitIdle();

    // 300 mismatching writes: the error count pins at 255.
    faultLat = 1'b1;
    wr_data = 8'hC3;
    wr_req = 1'b1;
    repeat (300 * (S0 + P0 + H0 + 2)) stepCycle();
    wr_req = 1'b0;
    waitIdle();
    checkOutput("errcnt_sat", errCnt0, 255);
    repeat (3) stepCycle();
    checkOutput("errcnt_sat_hold", errCnt0, 255);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/latch_write_ctrl.md
LATCH_WRITE_CTRL -- requirements
Module: latch_write_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; the ports are named clk and rst.
REQ-002 Parameter DATA_W, default 8: width of the latch data bus, legal range 1..32.
REQ-003 Parameter SETUP_CYC, default 2: cycles lat_d is stable before lat_e rises, legal range 1..255.
REQ-004 Parameter PULSE_CYC, default 3: cycles lat_e is held high, legal range 1..255.
REQ-005 Parameter HOLD_CYC, default 2: cycles lat_d is held after lat_e falls, legal range 1..255.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port wr_req, input, 1: write request from the host.
REQ-009 Port wr_data, input, DATA_W: value to write into the latch bank.
REQ-010 Port wr_ready, output, 1: controller is idle and can accept a request.
REQ-011 Port lat_d, output, DATA_W: data driven to the latch D inputs.
REQ-012 Port lat_e, output, 1: latch enable, level-sensitive, active high.
REQ-013 Port lat_q, input, DATA_W: latch Q outputs, read back for checking.
REQ-014 Port done, output, 1: one-cycle pulse when a write sequence completes.
REQ-015 Port err, output, 1: one-cycle pulse, coincident with done, when the readback mismatches.
REQ-016 Port err_cnt, output, 8: saturating count of readback mismatches.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD and CHECK; all outputs SHALL be registered.
REQ-018 wr_ready SHALL be 1 only in IDLE; a request is accepted on a rising clk edge with wr_req=1 and wr_ready=1.
REQ-019 On acceptance, wr_data SHALL be captured into an internal register and driven on lat_d from the next cycle; the FSM SHALL go to SETUP.
REQ-020 SETUP SHALL last exactly SETUP_CYC cycles with lat_e=0, then go to PULSE.
REQ-021 PULSE SHALL last exactly PULSE_CYC cycles with lat_e=1, then go to HOLD.
REQ-022 HOLD SHALL last exactly HOLD_CYC cycles with lat_e=0 and lat_d unchanged, then go to CHECK.
REQ-023 CHECK SHALL last one cycle and compare lat_q with the captured data; done=1 for that cycle; err=1 if they differ; the FSM then returns to IDLE.
REQ-024 The latency from the acceptance edge to done high SHALL be SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles (8 with defaults).
REQ-025 lat_d SHALL keep the last written value in IDLE, and SHALL change only on acceptance.
REQ-026 wr_req and wr_data SHALL be ignored while wr_ready=0; no queuing.
REQ-027 A request asserted in the same cycle that CHECK completes SHALL NOT be accepted; it is accepted on the first IDLE edge, so back-to-back writes have at least one IDLE cycle between them.
REQ-028 err_cnt SHALL increment by 1 on each err pulse and saturate at 255 with no wrap.
REQ-029 The phase counter SHALL be 8 bits and reload at each state entry; no phase shall be shortened or extended by wr_req activity.
REQ-030 lat_e SHALL never be high outside PULSE, and lat_d SHALL never change while lat_e=1 or during HOLD.

Reset
REQ-031 While rst=1, with no clock required: state=IDLE, wr_ready=1, lat_d=0, lat_e=0, done=0, err=0, err_cnt=0.
REQ-032 Reset asserted mid-sequence SHALL drop lat_e to 0 immediately and abort the write without a done or err pulse.
REQ-033 After rst deasserts, the first rising clk edge with wr_req=1 SHALL be accepted.

Verification
REQ-034 Use defaults with a model latch (Q follows D while E=1); write 0xA5 -> lat_d=0xA5 one cycle after acceptance; lat_e high for exactly 3 cycles after 2 setup cycles; done on cycle 8; err=0.
REQ-035 Use a faulty model latch with Q stuck at 0x00; write 0x3C -> done and err both pulse on cycle 8; err_cnt=1.
REQ-036 Hold wr_req=1 continuously with data 0x11 then 0x22 -> second acceptance occurs one IDLE cycle after done; lat_d never changes while lat_e=1.
REQ-037 Assert rst during PULSE -> lat_e=0 and lat_d=0 immediately; no done pulse; wr_ready=1.
REQ-038 Run 300 mismatching writes -> err_cnt reaches 255 and stays at 255.
REQ-039 Use SETUP_CYC=PULSE_CYC=HOLD_CYC=1 -> lat_e high for exactly 1 cycle; done 4 cycles after acceptance.
